// File: rtl/ps_pkg.sv
// Shared definitions for the pixel feeder: default frame geometry, FSM states
// and the tagged FIFO entry layout.
package ps_pkg;

    localparam int LINE_W  = 640;
    localparam int FRAME_H = 480;
    localparam int PIX_W   = 8;
    localparam int ENTRY_W = PIX_W + 2;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             sof;
        logic             eol;
    } entry_t;

endpackage

// File: rtl/ps_tag_fifo.sv
// Prefetch buffer for tagged pixels. Flush empties the buffer and may accept a
// write in the same cycle, which then becomes the only entry.
module ps_tag_fifo
    import ps_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          rd_en;

    assign o_full    = (count_q == (AW+1)'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_rd_data = rd_data_q;

    always_comb begin
        rd_en    = i_pop && !o_empty && !i_flush;
        wr_en    = i_push && (i_flush || !o_full);
        wr_addr  = i_flush ? '0 : wr_ptr_q;
        wr_ptr_d = wr_addr + AW'(wr_en);
        rd_ptr_d = i_flush ? '0 : rd_ptr_q + AW'(rd_en);
        if (i_flush) begin
            count_d = (AW+1)'(wr_en);
        end else begin
            count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage and read register carry no reset so they map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= i_wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

endmodule

// File: rtl/ps_pixel_feeder.sv
// Buffers an upstream raster stream and answers one-pixel requests in order,
// tagging frame start and end of line, with resync on a misplaced frame start.
module ps_pixel_feeder
    import ps_pkg::*;
#(
    parameter int LINE_W     = ps_pkg::LINE_W,
    parameter int FRAME_H    = ps_pkg::FRAME_H,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_PEND   = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [PIX_W-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_sof,
    output logic             o_ready,
    input  logic             i_req,
    output logic [PIX_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_sof,
    output logic             o_eol,
    output logic [1:0]       o_err
);

    localparam int COL_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int ROW_W  = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int PEND_W = $clog2(MAX_PEND + 1);

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [1:0]        err_q, err_d;
    logic              valid_q, valid_d;

    logic              fifo_full;
    logic              fifo_empty;
    entry_t            wr_entry;
    entry_t            rd_entry;
    logic [ENTRY_W-1:0] rd_raw;

    logic              accept;
    logic              start;
    logic              flush;
    logic              push;
    logic              pop;
    logic              req_ok;
    logic [COL_W-1:0]  pos_col;
    logic [ROW_W-1:0]  pos_row;

    always_comb begin
        o_ready = 1'b0;
        if (i_rstn) begin
            o_ready = (state_q == ST_SYNC) ? 1'b1 : !fifo_full;
        end
    end

    always_comb begin
        accept = i_valid && o_ready;
        // A frame start restarts the raster unless it lands exactly on (0,0).
        start  = accept && i_sof &&
                 ((state_q == ST_SYNC) || (col_q != '0) || (row_q != '0));
        flush  = start && (state_q == ST_RUN);
        push   = start || (accept && (state_q == ST_RUN));
        pop    = !flush && !fifo_empty && ((pend_q != '0) || i_req);
        req_ok = i_req && ((pend_q != PEND_W'(MAX_PEND)) || pop);

        pos_col = start ? '0 : col_q;
        pos_row = start ? '0 : row_q;

        wr_entry.pix = i_data;
        wr_entry.sof = (pos_col == '0) && (pos_row == '0);
        wr_entry.eol = (pos_col == COL_W'(LINE_W - 1));

        col_d = col_q;
        row_d = row_q;
        if (push) begin
            if (pos_col == COL_W'(LINE_W - 1)) begin
                col_d = '0;
                row_d = (pos_row == ROW_W'(FRAME_H - 1)) ? '0 : pos_row + ROW_W'(1);
            end else begin
                col_d = pos_col + COL_W'(1);
                row_d = pos_row;
            end
        end

        state_d = push ? ST_RUN : state_q;
        pend_d  = pend_q + PEND_W'(req_ok) - PEND_W'(pop);
        err_d   = err_q | {flush, i_req && !req_ok};
        valid_d = pop;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_SYNC;
            col_q   <= '0;
            row_q   <= '0;
            pend_q  <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    ps_tag_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_flush   (flush),
        .i_push    (push),
        .i_wr_data (wr_entry),
        .i_pop     (pop),
        .o_rd_data (rd_raw),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );

    // The read register holds stale data between pops, so outputs are gated.
    assign rd_entry = entry_t'(rd_raw);
    assign o_valid  = valid_q;
    assign o_data   = valid_q ? rd_entry.pix : '0;
    assign o_sof    = valid_q && rd_entry.sof;
    assign o_eol    = valid_q && rd_entry.eol;
    assign o_err    = err_q;

endmodule

// File: tb/tb_ps_pixel_feeder.sv
// Directed bench for ps_pixel_feeder: queue-based reference model checked every
// cycle, plus hand-computed expectations per scenario.
module tb_ps_pixel_feeder;

    localparam int LW = 640;
    localparam int FH = 480;
    localparam int FD = 16;
    localparam int MP = 16;

    logic       i_clk   = 1'b0;
    logic       i_rstn  = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic       i_valid = 1'b0;
    logic       i_sof   = 1'b0;
    logic       i_req   = 1'b0;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_sof;
    logic       o_eol;
    logic [1:0] o_err;

    ps_pixel_feeder #(
        .LINE_W     (LW),
        .FRAME_H    (FH),
        .FIFO_DEPTH (FD),
        .MAX_PEND   (MP)
    ) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_sof   (i_sof),
        .o_ready (o_ready),
        .i_req   (i_req),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_sof   (o_sof),
        .o_eol   (o_eol),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_edge = 0;

    typedef struct {
        logic [7:0] pix;
        bit         sof;
        bit         eol;
    } ent_t;

    typedef struct {
        int         c;
        logic [7:0] d;
        bit         s;
        bit         e;
    } rsp_t;

    // reference model state
    ent_t mq[$];
    int   m_pend = 0;
    bit   m_sync = 1'b1;
    int   m_col  = 0;
    int   m_row  = 0;
    bit [1:0] m_err = 2'b00;
    bit   m_live = 1'b0;
    bit   e_valid = 1'b0;
    logic [7:0] e_data = 8'h00;
    bit   e_sof = 1'b0;
    bit   e_eol = 1'b0;
    bit   e_ready;

    rsp_t rsp[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] pd(input int k);
        return 8'((k * 7 + 3) % 256);
    endfunction

    // One clock of the behavioural model, using the inputs present at the edge.
    task automatic model_step();
        bit   ready, acc, st, fl, psh, pp, rok;
        ent_t en;
        if (!i_rstn) begin
            mq.delete();
            m_pend = 0; m_sync = 1'b1; m_col = 0; m_row = 0; m_err = 2'b00;
            e_valid = 1'b0; e_data = 8'h00; e_sof = 1'b0; e_eol = 1'b0;
            m_live = 1'b1;
            return;
        end
        if (!m_live) return;
        ready = m_sync || (mq.size() < FD);
        acc   = i_valid && ready;
        st    = acc && i_sof && (m_sync || m_col != 0 || m_row != 0);
        fl    = st && !m_sync;
        psh   = st || (acc && !m_sync);
        pp    = !fl && (mq.size() > 0) && (m_pend > 0 || i_req);
        rok   = i_req && (m_pend < MP || pp);
        if (i_req && !rok) m_err[0] = 1'b1;
        e_valid = pp; e_data = 8'h00; e_sof = 1'b0; e_eol = 1'b0;
        if (pp) begin
            en = mq.pop_front();
            e_data = en.pix; e_sof = en.sof; e_eol = en.eol;
        end
        m_pend = m_pend + int'(rok) - int'(pp);
        if (fl) begin
            mq.delete();
            m_err[1] = 1'b1;
        end
        if (psh) begin
            if (st) begin
                m_col = 0; m_row = 0;
            end
            en.pix = i_data;
            en.sof = (m_col == 0 && m_row == 0);
            en.eol = (m_col == LW - 1);
            mq.push_back(en);
            m_col++;
            if (m_col == LW) begin
                m_col = 0;
                m_row = (m_row + 1) % FH;
            end
            m_sync = 1'b0;
        end
    endtask

    always @(posedge i_clk) begin
        cyc++;
        model_step();
        #1;
        if (m_live) begin
            e_ready = i_rstn && (m_sync || mq.size() < FD);
            check("o_valid", 32'(o_valid), 32'(e_valid));
            check("o_data",  32'(o_data),  32'(e_data));
            check("o_sof",   32'(o_sof),   32'(e_sof));
            check("o_eol",   32'(o_eol),   32'(e_eol));
            check("o_err",   32'(o_err),   32'(m_err));
            check("o_ready", 32'(o_ready), 32'(e_ready));
        end
        if (o_valid === 1'b1) rsp.push_back('{cyc, o_data, o_sof, o_eol});
    end

    task automatic drv(input bit v, input logic [7:0] d, input bit s, input bit r, output bit acc);
        @(negedge i_clk);
        i_valid = v; i_data = d; i_sof = s; i_req = r;
        last_edge = cyc + 1;
        #1;
        acc = v && (o_ready === 1'b1);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) drv(1'b0, 8'h00, 1'b0, 1'b0, a);
    endtask

    task automatic push_pix(input logic [7:0] d, input bit s, input bit r);
        bit acc;
        int n;
        n = 0;
        do begin
            drv(1'b1, d, s, r, acc);
            n++;
        end while (!acc && n < 200);
        check("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rstn = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_req = 1'b0; i_data = 8'h00;
        @(negedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at cycle %0d: got timeout want finish", cyc);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bit a;
        int k, req_e, neol, nord, nlat;
        int pe[20];

        // first pixel answered one cycle after a single request
        do_reset();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        rsp.delete();
        push_pix(8'hA5, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) push_pix(8'(8'h10 + i), 1'b0, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 1'b1, a);
        req_e = last_edge;
        idle(3);
        check("t1_count", 32'(rsp.size()), 32'd1);
        if (rsp.size() > 0) begin
            check("t1_data", 32'(rsp[0].d), 32'hA5);
            check("t1_sof", 32'(rsp[0].s), 32'd1);
            check("t1_latency", 32'(rsp[0].c), 32'(req_e));
        end

        // full line streamed against continuous requests
        do_reset();
        rsp.delete();
        push_pix(pd(0), 1'b1, 1'b0);
        for (k = 1; k < 16; k++) push_pix(pd(k), 1'b0, 1'b0);
        for (int i = 0; i < 640; i++) begin
            drv(1'b1, pd(k), 1'b0, 1'b1, a);
            if (a) k++;
        end
        idle(3);
        check("t2_count", 32'(rsp.size()), 32'd640);
        if (rsp.size() == 640) begin
            neol = 0; nord = 0;
            foreach (rsp[i]) begin
                if (rsp[i].e) neol++;
                if (rsp[i].d !== pd(i)) nord++;
            end
            check("t2_eol_count", 32'(neol), 32'd1);
            check("t2_eol_last", 32'(rsp[639].e), 32'd1);
            check("t2_order", 32'(nord), 32'd0);
            check("t2_first", 32'(rsp[0].d), 32'h03);
            check("t2_first_sof", 32'(rsp[0].s), 32'd1);
            check("t2_last", 32'(rsp[639].d), 32'h7C);
            check("t2_consecutive", 32'(rsp[639].c - rsp[0].c), 32'd639);
        end

        // requests waiting on an empty buffer
        do_reset();
        rsp.delete();
        for (int i = 0; i < 16; i++) drv(1'b0, 8'h00, 1'b0, 1'b1, a);
        for (int i = 0; i < 20; i++) begin
            push_pix(pd(i), i == 0, 1'b0);
            pe[i] = last_edge;
        end
        idle(3);
        check("t3_count", 32'(rsp.size()), 32'd16);
        check("t3_err", 32'(o_err), 32'd0);
        if (rsp.size() == 16) begin
            nlat = 0;
            foreach (rsp[i]) if (rsp[i].c != pe[i] + 1) nlat++;
            check("t3_latency", 32'(nlat), 32'd0);
            check("t3_sof", 32'(rsp[0].s), 32'd1);
        end

        // request overflow
        do_reset();
        rsp.delete();
        for (int i = 0; i < 17; i++) drv(1'b0, 8'h00, 1'b0, 1'b1, a);
        idle(1);
        check("t4_err", 32'(o_err), 32'd1);
        for (int i = 0; i < 20; i++) push_pix(pd(i), i == 0, 1'b0);
        idle(3);
        check("t4_count", 32'(rsp.size()), 32'd16);

        // pre-sync discard and mid-line resync
        do_reset();
        rsp.delete();
        for (int i = 0; i < 5; i++) drv(1'b1, 8'(8'hF0 + i), 1'b0, 1'b0, a);
        push_pix(8'h11, 1'b1, 1'b1);
        for (int i = 1; i < 100; i++) push_pix(8'(i), 1'b0, 1'b1);
        push_pix(8'hEE, 1'b1, 1'b1);
        idle(4);
        check("t5_err", 32'(o_err), 32'd2);
        check("t5_count", 32'(rsp.size()), 32'd100);
        if (rsp.size() == 100) begin
            check("t5_first", 32'(rsp[0].d), 32'h11);
            check("t5_first_sof", 32'(rsp[0].s), 32'd1);
            check("t5_before", 32'(rsp[98].d), 32'h62);
            check("t5_resync", 32'(rsp[99].d), 32'hEE);
            check("t5_resync_sof", 32'(rsp[99].s), 32'd1);
        end

        // reset with outstanding requests
        do_reset();
        for (int i = 0; i < 4; i++) push_pix(pd(i), i == 0, 1'b1);
        for (int i = 0; i < 5; i++) drv(1'b0, 8'h00, 1'b0, 1'b1, a);
        do_reset();
        rsp.delete();
        idle(5);
        check("t6_quiet", 32'(rsp.size()), 32'd0);
        for (int i = 0; i < 3; i++) drv(1'b1, 8'h55, 1'b0, 1'b0, a);
        drv(1'b0, 8'h00, 1'b0, 1'b1, a);
        idle(3);
        check("t6_wait", 32'(rsp.size()), 32'd0);
        push_pix(8'h77, 1'b1, 1'b0);
        idle(3);
        check("t6_count", 32'(rsp.size()), 32'd1);
        if (rsp.size() == 1) begin
            check("t6_data", 32'(rsp[0].d), 32'h77);
            check("t6_sof", 32'(rsp[0].s), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
